// File: rtl/timing_gen.sv
// Beat/phase sequencer for the hardwired controller: w1-w3 beats, t1-t3 phases.
// Optional single-step runs enabled by defining SINGLE_STEP_EN.
module timing_gen #(
  parameter bit RUN_ON_RESET = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  input  logic             step,
  output logic             running,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             t1,
  output logic             t2,
  output logic             t3,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {
    BEAT_W1 = 2'd0,
    BEAT_W2 = 2'd1,
    BEAT_W3 = 2'd2
  } beat_t;

  typedef enum logic [1:0] {
    PH_T1 = 2'd0,
    PH_T2 = 2'd1,
    PH_T3 = 2'd2
  } phase_t;

  logic             run;
  logic             run_n;
  beat_t            beat;
  beat_t            beat_n;
  beat_t            end_beat;
  phase_t           phase;
  phase_t           phase_n;
  logic [CNT_W-1:0] cnt_n;
  logic             go;

`ifdef SINGLE_STEP_EN
  logic smode;
  logic smode_n;

  assign go = start | step;
`else
  logic step_unused;

  assign step_unused = step;
  assign go          = start;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      run     <= RUN_ON_RESET;
      beat    <= BEAT_W1;
      phase   <= PH_T1;
      cyc_cnt <= '0;
    end else begin
      run     <= run_n;
      beat    <= beat_n;
      phase   <= phase_n;
      cyc_cnt <= cnt_n;
    end
  end

`ifdef SINGLE_STEP_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) smode <= 1'b0;
    else     smode <= smode_n;
  end
`endif

  always_comb begin
    run_n    = run;
    beat_n   = beat;
    phase_n  = phase;
    cnt_n    = cyc_cnt;
    end_beat = BEAT_W1;
`ifdef SINGLE_STEP_EN
    smode_n  = smode;
`endif
    if (!run) begin
      beat_n  = BEAT_W1;
      phase_n = PH_T1;
      if (go) begin
        run_n = 1'b1;
`ifdef SINGLE_STEP_EN
        smode_n = step;
`endif
      end
    end else begin
      unique case (phase)
        PH_T1: phase_n = PH_T2;
        PH_T2: phase_n = PH_T3;
        PH_T3: begin
          phase_n = PH_T1;
          unique case (beat)
            BEAT_W1: end_beat = short ? BEAT_W1 : BEAT_W2;
            BEAT_W2: end_beat = long ? BEAT_W3 : BEAT_W1;
            default: end_beat = BEAT_W1;
          endcase
          beat_n = end_beat;
          // stop forces the cycle closed, so it still counts
          if (stop) begin
            run_n  = 1'b0;
            beat_n = BEAT_W1;
          end
          if (beat_n == BEAT_W1) begin
            cnt_n = cyc_cnt + CNT_W'(1);
`ifdef SINGLE_STEP_EN
            if (smode) run_n = 1'b0;
`endif
          end
        end
        default: phase_n = PH_T1;
      endcase
    end
  end

  assign running = run;
  assign w1      = (beat == BEAT_W1);
  assign w2      = (beat == BEAT_W2);
  assign w3      = (beat == BEAT_W3);
  assign t1      = run && (phase == PH_T1);
  assign t2      = run && (phase == PH_T2);
  assign t3      = run && (phase == PH_T3);

endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
- Beat/phase sequencer that drives the hardwired controller's timing inputs: w1, w2, w3 (beats) and t1, t2, t3 (phases).
- Consumes the controller's short, long and stop outputs to size each machine cycle (W1 only, W1-W2, or W1-W2-W3), and halts and restarts on the console start button.
- Sits between the front-panel start input and the controller; the controller's st0 register is clocked by this block's t3.

Parameters:
- RUN_ON_RESET, 0, 1 = enter RUN directly out of reset; 0 = wait in IDLE for start.
- CNT_W, 16, width of the completed machine-cycle counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  asynchronous, active-high reset.
- start  input  1  console start (QD), synchronous level, sampled only in IDLE.
- short  input  1  from controller; cycle ends after W1.
- long  input  1  from controller; cycle extends to W3.
- stop  input  1  from controller; halt at end of current beat.
- step  input  1  single-step request; used only with SINGLE_STEP_EN.
- running  output  1  1 in RUN state.
- w1, w2, w3  output  1 each  one-hot beat decode.
- t1, t2, t3  output  1 each  one-hot phase decode; all 0 in IDLE.
- cyc_cnt  output  CNT_W  completed machine cycles, wraps.

Behaviour:
- State:
  - run flag: IDLE or RUN.
  - beat: W1, W2 or W3.
  - phase: T1, T2 or T3.
  - cyc_cnt.
- Reset, asynchronous on clr=1:
  - run = RUN_ON_RESET, beat = W1, phase = T1, cyc_cnt = 0.
  - Outputs after reset: w1=1, w2=w3=0; t1=RUN_ON_RESET, t2=t3=0; running=RUN_ON_RESET.
- w outputs decode beat in both states. In IDLE the beat is always W1, so w1=1 lets the controller decode panel operations. t outputs decode phase only when run=1.
- IDLE -> RUN: start=1 at a clk edge. The next cycle shows t1=1 with beat W1.
- start while in RUN is ignored.
- RUN phase sequence: T1 -> T2 -> T3 -> T1, one clk per phase, so one beat is 3 clk cycles. t3 is exactly one cycle wide.
- Beat decision at the clk edge that ends T3, evaluated on short/long/stop as sampled in T3, in priority order:
  1. stop=1: run <= 0, beat <= W1, phase <= T1 (t outputs go 0).
  2. beat W1: short=1 -> W1; otherwise -> W2. long is ignored in W1.
  3. beat W2: long=1 -> W3; otherwise -> W1. short is ignored in W2.
  4. beat W3 -> W1 unconditionally.
- Completion: any T3 edge whose next beat is W1, including a stop, increments cyc_cnt by 1 modulo 2^CNT_W.
- short and long both high in W1: short wins and the cycle ends.
- stop asserted in T1 or T2 has no effect unless it is still high in T3.
- start=1 on the same edge that stop halts: the halt wins, and start is honoured only from IDLE on a later edge.
- Reset mid-beat: immediate return to the reset state. No partial count is recorded.
- No combinational path from short/long/stop to any output; all outputs are registered or decoded from registered state.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - step=1 in IDLE behaves like start.
  - The step input is latched when the run begins.
  - A run begun by step halts to IDLE at the first completion (next beat W1) even if stop=0; cyc_cnt still increments.
  - A run begun by start behaves normally.
- Undefined:
  - The step port exists but is ignored.
  - Only start and stop control the run state.

Test Plan:
- Reset with RUN_ON_RESET=0, then hold clr=0 for 5 clks with start=0 -> w1=1, t1=t2=t3=0, running=0, cyc_cnt=0 throughout.
- Pulse start one clk, short=1 held -> t1,t2,t3 cycle with period 3 and beat stays W1; cyc_cnt=3 after 9 RUN clks.
- short=0, long=1 held -> beat pattern W1,W2,W3 with each beat 3 clks; cyc_cnt increments once per 9 clks; w2 and w3 each high exactly 3 clks per cycle.
- short=0, long=0, stop=1 asserted only during T3 of W2 -> after that edge running=0, w1=1, t all 0, cyc_cnt +1; start restarts at W1/T1.
- Assert clr during T2 of W3 with cyc_cnt=7 -> immediately w1=1, t all 0 (RUN_ON_RESET=0), cyc_cnt=0.
- With SINGLE_STEP_EN: step pulse, long=1 -> exactly 9 RUN clks (W1,W2,W3), then IDLE with cyc_cnt +1; a second step repeats the same 9 clks.
